// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between the CPU and the IO/DMA requester.
// One transaction runs at a time. IO writes below IO_MEM are dropped and flagged.
module mem_port_arbiter #(
    parameter int unsigned      WIDTH        = 16,
    parameter logic [WIDTH-1:0] IO_MEM       = WIDTH'(16'hCFFD),
    parameter bit               CPU_PRIORITY = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [WIDTH-1:0] cpu_adr,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic             cpu_gnt,
    output logic [WIDTH-1:0] cpu_rdata,
    output logic             cpu_rvalid,
    input  logic             io_req,
    input  logic             io_we,
    input  logic [WIDTH-1:0] io_adr,
    input  logic [WIDTH-1:0] io_wdata,
    output logic             io_gnt,
    output logic [WIDTH-1:0] io_rdata,
    output logic             io_rvalid,
    output logic             io_err,
    output logic [WIDTH-1:0] mem_adr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_we,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_IO  = 1'b1
    } owner_t;

    state_t state;
    owner_t owner;
    owner_t last_owner;
    logic   cmd_we;

    logic pick_cpu_c;
    logic io_write_ok_c;

    // Winner selection: a lone requester wins; a tie goes by priority or round-robin
    always_comb begin
        pick_cpu_c = 1'b0;
        if (cpu_req && !io_req) begin
            pick_cpu_c = 1'b1;
        end else if (cpu_req && io_req) begin
            pick_cpu_c = CPU_PRIORITY || (last_owner == OWN_IO);
        end
    end

    assign io_write_ok_c = (io_adr >= IO_MEM);
    assign busy          = (state != IDLE);

    // mem_adr/mem_wdata double as the captured command registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= OWN_CPU;
            last_owner <= OWN_IO;
            cmd_we     <= 1'b0;
            cpu_gnt    <= 1'b0;
            io_gnt     <= 1'b0;
            cpu_rvalid <= 1'b0;
            io_rvalid  <= 1'b0;
            io_err     <= 1'b0;
            mem_we     <= 1'b0;
            mem_adr    <= '0;
            mem_wdata  <= '0;
            cpu_rdata  <= '0;
            io_rdata   <= '0;
        end else begin
            cpu_gnt    <= 1'b0;
            io_gnt     <= 1'b0;
            cpu_rvalid <= 1'b0;
            io_rvalid  <= 1'b0;
            io_err     <= 1'b0;
            mem_we     <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req || io_req) begin
                        state <= ACCESS;
                        if (pick_cpu_c) begin
                            owner      <= OWN_CPU;
                            last_owner <= OWN_CPU;
                            cpu_gnt    <= 1'b1;
                            cmd_we     <= cpu_we;
                            mem_adr    <= cpu_adr;
                            mem_wdata  <= cpu_wdata;
                            mem_we     <= cpu_we;
                        end else begin
                            owner      <= OWN_IO;
                            last_owner <= OWN_IO;
                            io_gnt     <= 1'b1;
                            cmd_we     <= io_we;
                            mem_adr    <= io_adr;
                            mem_wdata  <= io_wdata;
                            mem_we     <= io_we && io_write_ok_c;
                            io_err     <= io_we && !io_write_ok_c;
                        end
                    end
                end
                ACCESS: begin
                    // A blocked IO write still completes as a write
                    state <= cmd_we ? IDLE : RESP;
                end
                RESP: begin
                    state <= IDLE;
                    if (owner == OWN_CPU) begin
                        cpu_rdata  <= mem_rdata;
                        cpu_rvalid <= 1'b1;
                    end else begin
                        io_rdata   <= mem_rdata;
                        io_rvalid  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: round-robin instance (a_) and CPU-priority instance (b_),
// both driven by the same requesters, each with its own synchronous RAM model.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_we, io_req, io_we;
    logic [15:0] cpu_adr, cpu_wdata, io_adr, io_wdata;

    logic        a_cpu_gnt, a_io_gnt, a_cpu_rvalid, a_io_rvalid, a_io_err, a_mem_we, a_busy;
    logic [15:0] a_cpu_rdata, a_io_rdata, a_mem_adr, a_mem_wdata, a_mem_rdata;
    logic        b_cpu_gnt, b_io_gnt, b_cpu_rvalid, b_io_rvalid, b_io_err, b_mem_we, b_busy;
    logic [15:0] b_cpu_rdata, b_io_rdata, b_mem_adr, b_mem_wdata, b_mem_rdata;

    logic [15:0] ram_a [0:65535];
    logic [15:0] ram_b [0:65535];

    logic [15:0] cpu_q [$];
    logic [15:0] io_q  [$];
    logic [15:0] cpu_last, io_last;
    int          n_cmp, n_err;

    mem_port_arbiter #(.WIDTH(16), .IO_MEM(16'hCFFD), .CPU_PRIORITY(1'b0)) dut_a (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(a_cpu_gnt), .cpu_rdata(a_cpu_rdata), .cpu_rvalid(a_cpu_rvalid),
        .io_req(io_req), .io_we(io_we), .io_adr(io_adr), .io_wdata(io_wdata),
        .io_gnt(a_io_gnt), .io_rdata(a_io_rdata), .io_rvalid(a_io_rvalid), .io_err(a_io_err),
        .mem_adr(a_mem_adr), .mem_wdata(a_mem_wdata), .mem_we(a_mem_we),
        .mem_rdata(a_mem_rdata), .busy(a_busy)
    );

    mem_port_arbiter #(.WIDTH(16), .IO_MEM(16'hCFFD), .CPU_PRIORITY(1'b1)) dut_b (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(b_cpu_gnt), .cpu_rdata(b_cpu_rdata), .cpu_rvalid(b_cpu_rvalid),
        .io_req(io_req), .io_we(io_we), .io_adr(io_adr), .io_wdata(io_wdata),
        .io_gnt(b_io_gnt), .io_rdata(b_io_rdata), .io_rvalid(b_io_rvalid), .io_err(b_io_err),
        .mem_adr(b_mem_adr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we),
        .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAMs: write on we, read data valid one cycle after the address edge
    always @(posedge clk) begin
        if (a_mem_we) ram_a[a_mem_adr] <= a_mem_wdata;
        a_mem_rdata <= ram_a[a_mem_adr];
        if (b_mem_we) ram_b[b_mem_adr] <= b_mem_wdata;
        b_mem_rdata <= ram_b[b_mem_adr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance to the next falling edge and score any read response of instance a
    task automatic tick();
        logic [15:0] e;
        @(negedge clk);
        if (a_cpu_rvalid) begin
            if (cpu_q.size() == 0) begin
                check("cpu_rvalid_unexpected", 32'(1), 32'(0));
            end else begin
                e = cpu_q.pop_front();
                check("cpu_rdata", 32'(a_cpu_rdata), 32'(e));
                cpu_last = e;
            end
            check("io_rdata_hold", 32'(a_io_rdata), 32'(io_last));
        end
        if (a_io_rvalid) begin
            if (io_q.size() == 0) begin
                check("io_rvalid_unexpected", 32'(1), 32'(0));
            end else begin
                e = io_q.pop_front();
                check("io_rdata", 32'(a_io_rdata), 32'(e));
                io_last = e;
            end
            check("cpu_rdata_hold", 32'(a_cpu_rdata), 32'(cpu_last));
        end
    endtask

    // Present a command and hold it until granted; drops req in the grant cycle
    task automatic issue(input bit to_io, input bit we, input logic [15:0] adr,
                         input logic [15:0] wdata, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        if (to_io) begin
            io_req = 1'b1; io_we = we; io_adr = adr; io_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_adr = adr; cpu_wdata = wdata;
        end
        for (int i = 0; i < 12 && !seen; i++) begin
            tick();
            lat++;
            seen = to_io ? a_io_gnt : a_cpu_gnt;
        end
        if (!seen) check("gnt_timeout", 32'(0), 32'(1));
        if (to_io) io_req = 1'b0;
        else       cpu_req = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cpu_last = '0;
        io_last  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit ec, ei;
        n_cmp = 0; n_err = 0;
        cpu_last = '0; io_last = '0;
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_adr = '0; cpu_wdata = '0;
        io_req  = 1'b0; io_we  = 1'b0; io_adr  = '0; io_wdata  = '0;
        tick();
        tick();

        // Reset state of both instances
        check("rst_pulses_a", 32'({a_cpu_gnt, a_io_gnt, a_cpu_rvalid, a_io_rvalid, a_io_err, a_mem_we, a_busy}), 32'(0));
        check("rst_mem_a", 32'({a_mem_adr, a_mem_wdata}), 32'(0));
        check("rst_rdata_a", 32'({a_cpu_rdata, a_io_rdata}), 32'(0));
        check("rst_pulses_b", 32'({b_cpu_gnt, b_io_gnt, b_cpu_rvalid, b_io_rvalid, b_io_err, b_mem_we, b_busy}), 32'(0));
        check("rst_regs_b", 32'({b_mem_adr, b_mem_wdata} ^ {b_cpu_rdata, b_io_rdata}), 32'(0));
        reset = 1'b0;
        tick();

        // Reset asserted during the ACCESS cycle of a CPU write
        issue(1'b0, 1'b1, 16'h6FFE, 16'h1111, lat);
        check("rstmid_we_before", 32'(a_mem_we), 32'(1));
        check("rstmid_busy_before", 32'(a_busy), 32'(1));
        reset = 1'b1;
        #1;
        check("rstmid_we_async", 32'(a_mem_we), 32'(0));
        check("rstmid_busy_async", 32'(a_busy), 32'(0));
        check("rstmid_gnt_async", 32'(a_cpu_gnt), 32'(0));
        tick();
        reset = 1'b0;
        cpu_last = '0; io_last = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rstmid_quiet", 32'({a_cpu_gnt, a_io_gnt, a_cpu_rvalid, a_io_rvalid, a_busy, a_mem_we}), 32'(0));
        end

        // CPU write 1234 to 6FFE, then read it back with req held through the write grant
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 16'h6FFE; cpu_wdata = 16'h1234;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("wr_rd_gnt", 32'(a_cpu_gnt), 32'(k == 1 || k == 3));
            check("wr_rd_we", 32'(a_mem_we), 32'(k == 1));
            check("wr_rd_rvalid", 32'(a_cpu_rvalid), 32'(k == 5));
            if (k == 1) begin
                cpu_we = 1'b0;
                cpu_q.push_back(16'h1234);
            end
            if (k == 3) cpu_req = 1'b0;
        end

        // IO window: blocked below IO_MEM, allowed at IO_MEM exactly
        issue(1'b0, 1'b1, 16'h0010, 16'h7777, lat);
        tick();
        issue(1'b1, 1'b1, 16'h0010, 16'hBEEF, lat);
        check("io_blk_err", 32'(a_io_err), 32'(1));
        check("io_blk_we", 32'(a_mem_we), 32'(0));
        tick();
        check("io_blk_err_end", 32'({a_io_err, a_mem_we, a_busy}), 32'(0));
        check("io_blk_ram", 32'(ram_a[16'h0010]), 32'(16'h7777));
        issue(1'b1, 1'b1, 16'hCFFC, 16'hDEAD, lat);
        check("io_edge_err", 32'(a_io_err), 32'(1));
        check("io_edge_we", 32'(a_mem_we), 32'(0));
        tick();
        issue(1'b1, 1'b1, 16'hCFFD, 16'h5A5A, lat);
        check("io_ok_we", 32'(a_mem_we), 32'(1));
        check("io_ok_err", 32'(a_io_err), 32'(0));
        tick();
        check("io_ok_end", 32'({a_io_err, a_mem_we}), 32'(0));
        check("io_ok_ram", 32'(ram_a[16'hCFFD]), 32'(16'h5A5A));

        // Back-to-back CPU and IO reads: each rdata moves only on its own rvalid
        cpu_q.push_back(16'h1234);
        issue(1'b0, 1'b0, 16'h6FFE, 16'h0000, lat);
        io_q.push_back(16'h5A5A);
        issue(1'b1, 1'b0, 16'hCFFD, 16'h0000, lat);
        check("b2b_io_lat", 32'(lat), 32'(3));
        cpu_q.push_back(16'h7777);
        issue(1'b0, 1'b0, 16'h0010, 16'h0000, lat);
        check("b2b_cpu_lat", 32'(lat), 32'(3));
        tick();
        tick();
        check("b2b_cpu_final", 32'(a_cpu_rdata), 32'(16'h7777));
        check("b2b_io_final", 32'(a_io_rdata), 32'(16'h5A5A));

        // Ties: both requesters hold reads; a alternates from CPU, b always grants CPU
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 16'h6FFE;
        io_req  = 1'b1; io_we  = 1'b0; io_adr  = 16'hCFFD;
        for (int k = 1; k <= 13; k++) begin
            tick();
            ec = (k % 3 == 1) && k <= 10 && (((k - 1) / 3) % 2 == 0);
            ei = (k % 3 == 1) && k <= 10 && (((k - 1) / 3) % 2 == 1);
            check("tie_rr_cpu_gnt", 32'(a_cpu_gnt), 32'(ec));
            check("tie_rr_io_gnt", 32'(a_io_gnt), 32'(ei));
            check("tie_pri_cpu_gnt", 32'(b_cpu_gnt), 32'((k % 3 == 1) && k <= 10));
            check("tie_pri_io_gnt", 32'(b_io_gnt), 32'(0));
            if (ec) cpu_q.push_back(16'h1234);
            if (ei) io_q.push_back(16'h5A5A);
            if (k == 10) begin
                cpu_req = 1'b0;
                io_req  = 1'b0;
            end
        end
        check("queues_drained", 32'(cpu_q.size() + io_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
